// File: rtl/sync_filter_multi.sv
// Multi-channel pad input conditioner: per-bit flop synchronizer followed by a
// consecutive-sample stability filter with registered rise/fall event pulses.
`timescale 1ns/100ps
module sync_filter_multi #(
  parameter int               WIDTH      = 4,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 3,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             filt_q;
    logic             rise_q;
    logic             fall_q;

    // An unknown sample fails the equality test against ~filt_q and so clears the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        filt_q <= RESET_VAL[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_out[i] == ~filt_q) begin
          if (cnt == CNT_LAST) begin
            filt_q <= sync_out[i];
            rise_q <= sync_out[i];
            fall_q <= ~sync_out[i];
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign filt_out[i] = filt_q;
    assign rise[i]     = rise_q;
    assign fall[i]     = fall_q;
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Self-checking bench for sync_filter_multi: directed scenarios plus random
// stimulus compared every cycle against a window-based reference model.
`timescale 1ns/100ps
module tb_sync_filter_multi;

  localparam int         WIDTH      = 4;
  localparam int         STAGES     = 2;
  localparam int         FILTER_LEN = 3;
  localparam logic [3:0] RV         = 4'b0101;

  logic       tb_clk   = 1'b0;
  logic       tb_rst   = 1'b0;
  logic [3:0] tb_async = 4'b1010;
  logic [3:0] sync_out, filt_out, rise, fall;

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  sync_filter_multi #(
    .WIDTH(WIDTH), .STAGES(STAGES), .FILTER_LEN(FILTER_LEN), .RESET_VAL(RV)
  ) dut (
    .clk(tb_clk), .rst(tb_rst), .async_in(tb_async),
    .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    @(negedge tb_clk);
    tb_async = value;
  endtask

  // Reference model: sync_out is the input sampled STAGES edges ago; filt_out
  // flips when the last FILTER_LEN sampled sync values all disagree with it.
  logic [3:0] m_async_q [$];
  logic [3:0] m_samp_q  [$];
  logic [3:0] m_sync = 4'b0000, m_filt = 4'b0000, m_rise = 4'b0000, m_fall = 4'b0000;

  always @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      m_async_q.delete();
      m_samp_q.delete();
      m_sync = RV;
      m_filt = RV;
      m_rise = '0;
      m_fall = '0;
    end else begin
      m_samp_q.push_back(m_sync);
      m_async_q.push_back(tb_async);
      if (m_async_q.size() >= STAGES) m_sync = m_async_q[m_async_q.size()-STAGES];
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < WIDTH; ch++) begin
        bit stable;
        stable = (m_samp_q.size() >= FILTER_LEN);
        for (int k = 1; k <= FILTER_LEN && stable; k++)
          if (m_samp_q[m_samp_q.size()-k][ch] == m_filt[ch]) stable = 1'b0;
        if (stable) begin
          m_filt[ch] = ~m_filt[ch];
          m_rise[ch] = m_filt[ch];
          m_fall[ch] = ~m_filt[ch];
        end
      end
      if (m_async_q.size() > 8) void'(m_async_q.pop_front());
      if (m_samp_q.size() > 8) void'(m_samp_q.pop_front());
    end
  end

  always @(negedge tb_clk) begin
    if (check_en) begin
      checkOutput("sync_out", 32'(sync_out), 32'(m_sync));
      checkOutput("filt_out", 32'(filt_out), 32'(m_filt));
      checkOutput("rise", 32'(rise), 32'(m_rise));
      checkOutput("fall", 32'(fall), 32'(m_fall));
    end
  end

  task automatic runGlitch(input int hold, output int sync_hi, output int filt_hi,
                           output int rise_n, output int fall_n,
                           output int rise_at, output int fall_at);
    sync_hi = 0; filt_hi = 0; rise_n = 0; fall_n = 0; rise_at = 0; fall_at = 0;
    applyStimulus(tb_async | 4'b1000);
    for (int c = 1; c <= 12; c++) begin
      @(posedge tb_clk);
      #1;
      if (sync_out[3]) sync_hi++;
      if (filt_out[3]) filt_hi++;
      if (rise[3]) begin rise_n++; rise_at = c; end
      if (fall[3]) begin fall_n++; fall_at = c; end
      if (c == hold) applyStimulus(tb_async & 4'b0111);
    end
  endtask

  int sync_hi, filt_hi, rise_n, fall_n, rise_at, fall_at;

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #1 tb_rst = 1'b1;
    #1;
    checkOutput("rst_sync", 32'(sync_out), 32'(RV));
    checkOutput("rst_filt", 32'(filt_out), 32'(RV));
    checkOutput("rst_rise", 32'(rise), 32'h0);
    checkOutput("rst_fall", 32'(fall), 32'h0);
    repeat (2) @(posedge tb_clk);
    #1;
    checkOutput("rst_hold_sync", 32'(sync_out), 32'(RV));
    checkOutput("rst_hold_filt", 32'(filt_out), 32'(RV));
    @(posedge tb_clk);
    #0.2 tb_rst = 1'b0;
    check_en = 1'b1;
    #1;
    checkOutput("rel_sync", 32'(sync_out), 32'(RV));
    checkOutput("rel_filt", 32'(filt_out), 32'(RV));
    checkOutput("rel_rise", 32'(rise), 32'h0);
    checkOutput("rel_fall", 32'(fall), 32'h0);
    repeat (10) @(posedge tb_clk);

    // Clean step on channel 1.
    applyStimulus(4'b0000);
    repeat (10) @(posedge tb_clk);
    applyStimulus(4'b0010);
    repeat (2) @(posedge tb_clk);
    #1 checkOutput("step_sync_e2", 32'(sync_out[1]), 32'h1);
    repeat (2) @(posedge tb_clk);
    #1 checkOutput("step_filt_e4", 32'(filt_out[1]), 32'h0);
    @(posedge tb_clk);
    #1;
    checkOutput("step_filt_e5", 32'(filt_out[1]), 32'h1);
    checkOutput("step_rise_e5", 32'(rise), 32'b0010);
    checkOutput("step_fall_e5", 32'(fall), 32'b0000);
    @(posedge tb_clk);
    #1 checkOutput("step_rise_e6", 32'(rise), 32'h0);
    repeat (6) @(posedge tb_clk);

    runGlitch(2, sync_hi, filt_hi, rise_n, fall_n, rise_at, fall_at);
    checkOutput("rej_sync_hi", 32'(sync_hi), 32'd2);
    checkOutput("rej_filt_hi", 32'(filt_hi), 32'd0);
    checkOutput("rej_rise_n", 32'(rise_n), 32'd0);

    runGlitch(3, sync_hi, filt_hi, rise_n, fall_n, rise_at, fall_at);
    checkOutput("pass_filt_hi", 32'(filt_hi), 32'd3);
    checkOutput("pass_rise_n", 32'(rise_n), 32'd1);
    checkOutput("pass_fall_n", 32'(fall_n), 32'd1);
    checkOutput("pass_gap", 32'(fall_at - rise_at), 32'd3);

    // Reset while channel 1's count is in progress.
    applyStimulus(4'b0000);
    repeat (10) @(posedge tb_clk);
    applyStimulus(4'b0010);
    repeat (4) @(posedge tb_clk);
    #1 tb_rst = 1'b1;
    #1 checkOutput("mid_rst_filt", 32'(filt_out), 32'(RV));
    #1 tb_rst = 1'b0;
    repeat (4) @(posedge tb_clk);
    #1 checkOutput("mid_filt_e4", 32'(filt_out[1]), 32'h0);
    @(posedge tb_clk);
    #1 checkOutput("mid_filt_e5", 32'(filt_out[1]), 32'h1);
    repeat (8) @(posedge tb_clk);

    // Simultaneous events on channels 0 and 2.
    applyStimulus(4'b0011);
    repeat (10) @(posedge tb_clk);
    applyStimulus(4'b0110);
    repeat (5) @(posedge tb_clk);
    #1;
    checkOutput("simul_pair", 32'({fall[0], rise[2]}), 32'b11);
    checkOutput("simul_rise", 32'(rise), 32'b0100);
    checkOutput("simul_fall", 32'(fall), 32'b0001);
    repeat (6) @(posedge tb_clk);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(4'($urandom));
      repeat ($urandom_range(0, 4)) @(posedge tb_clk);
    end
    repeat (10) @(posedge tb_clk);

    // Unknown and edge-hugging input updates: only the filtered level's validity is checked.
    @(negedge tb_clk);
    check_en = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge tb_clk);
      #0.1 tb_async = (n % 2 == 1) ? 4'bxxxx : 4'($urandom);
      #1 checkOutput("filt_known", 32'($isunknown(filt_out)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
